// File: rtl/bsearch_pkg.sv
// Shared types for the binary-search engine: FSM state encoding.
package bsearch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    WAIT,
    COMPARE,
    DONE
  } state_t;

endpackage

// File: rtl/bsearch_dp.sv
// Binary-search datapath: captured target/order, low/high/mid pointers,
// read-latency wait counter, probe counter, comparators and result registers.
module bsearch_dp
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_i,
  input  logic              calc_i,
  input  logic              wait_i,
  input  logic              cmp_i,
  input  logic [DATA_W-1:0] target_i,
  input  logic              desc_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              wait_done_o,
  output logic              eq_o,
  output logic              miss_o,
  output logic              found_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W:0]   probes_o
);

  localparam int PW = ADDR_W + 1;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [PW-1:0] TOP   = PW'((2 ** ADDR_W) - 1);
  localparam logic [CW-1:0] WLAST = CW'(RD_LAT - 1);

  logic [DATA_W-1:0] tgt_q;
  logic              desc_q;
  logic [PW-1:0]     low_q, low_d, high_q, high_d, mid_q, mid_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [PW-1:0]     probes_q, probes_d;
  logic              found_q, found_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              gt;
  logic [PW-1:0]     low_up, high_dn;

  assign eq_o    = (rd_data_i == tgt_q);
  assign gt      = desc_q ? (tgt_q < rd_data_i) : (tgt_q > rd_data_i);
  assign low_up  = mid_q + 1'b1;
  assign high_dn = mid_q - 1'b1;

  // high only goes negative via mid == 0; checking that directly keeps the
  // pointer compares unsigned while low may still reach DEPTH.
  assign miss_o = !eq_o && (gt ? (low_up > high_q)
                               : ((mid_q == '0) || (low_q > high_dn)));

  assign wait_done_o = (wcnt_q == WLAST);

  always_comb begin
    low_d    = low_q;
    high_d   = high_q;
    mid_d    = mid_q;
    wcnt_d   = wcnt_q;
    probes_d = probes_q;
    found_d  = found_q;
    addr_d   = addr_q;
    if (init_i) begin
      low_d    = '0;
      high_d   = TOP;
      found_d  = 1'b0;
      addr_d   = '0;
      probes_d = '0;
    end
    if (calc_i) begin
      mid_d    = low_q + ((high_q - low_q) >> 1);
      probes_d = probes_q + 1'b1;
      wcnt_d   = '0;
    end
    if (wait_i && !wait_done_o) wcnt_d = wcnt_q + 1'b1;
    if (cmp_i) begin
      if (eq_o) begin
        found_d = 1'b1;
        addr_d  = mid_q[ADDR_W-1:0];
      end else if (gt) begin
        low_d = low_up;
      end else begin
        high_d = high_dn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      low_q    <= '0;
      high_q   <= TOP;
      mid_q    <= '0;
      wcnt_q   <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      low_q    <= low_d;
      high_q   <= high_d;
      mid_q    <= mid_d;
      wcnt_q   <= wcnt_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      addr_q   <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (init_i) begin
      tgt_q  <= target_i;
      desc_q <= desc_i;
    end
  end

  assign rd_addr_o = mid_q[ADDR_W-1:0];
  assign found_o   = found_q;
  assign addr_o    = addr_q;
  assign probes_o  = probes_q;

endmodule

// File: rtl/bsearch_engine.sv
// Binary-search engine top: control FSM driving bsearch_dp against an
// external synchronous-read table RAM.
module bsearch_engine
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] target,
  input  logic              descending,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   probes
);

  state_t state_q, state_d;
  logic   init, calc, wait_st, cmp;
  logic   wait_done, eq, miss;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    state_d = WAIT;
      WAIT:    if (wait_done) state_d = COMPARE;
      COMPARE: state_d = (eq || miss) ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    init    = (state_q == IDLE) && start;
    calc    = (state_q == CALC);
    wait_st = (state_q == WAIT);
    cmp     = (state_q == COMPARE);
  end

  bsearch_dp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_dp (
    .clk        (clk),
    .reset      (reset),
    .init_i     (init),
    .calc_i     (calc),
    .wait_i     (wait_st),
    .cmp_i      (cmp),
    .target_i   (target),
    .desc_i     (descending),
    .rd_data_i  (rd_data),
    .rd_addr_o  (rd_addr),
    .wait_done_o(wait_done),
    .eq_o       (eq),
    .miss_o     (miss),
    .found_o    (found),
    .addr_o     (addr),
    .probes_o   (probes)
  );

endmodule
